// File: rtl/perf_counter_pkg.sv
// Shared definitions for the performance counter: FSM encodings, display
// select codes and status-word bit positions.
package perf_counter_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [1:0] SEL_CYC  = 2'd0;
  localparam logic [1:0] SEL_INS  = 2'd1;
  localparam logic [1:0] SEL_STL  = 2'd2;
  localparam logic [1:0] SEL_STAT = 2'd3;

  localparam int unsigned STAT_RUNNING_BIT = 0;
  localparam int unsigned STAT_DONE_BIT    = 1;
  localparam int unsigned STAT_OVF_BIT     = 2;

endpackage

// File: rtl/perf_counter_sat_counter.sv
// Saturating up-counter. Holds at all-ones; sat_hit flags an increment
// request that arrives while the counter is already saturated.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             sat_hit
);

  logic [WIDTH-1:0] r_q;
  logic             w_at_max;

  assign w_at_max = &r_q;
  assign sat_hit  = en & w_at_max;
  assign q        = r_q;

  // Count register: increment when enabled, freeze at the maximum value
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= '0;
    end else if (en && !w_at_max) begin
      r_q <= r_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/perf_counter.sv
// Performance counter top: run-control FSM, cycle/instruction (and optional
// stall) counters, sticky overflow and registered display mux.
// Optional feature macro: PERF_STALL_COUNT_EN enables the stall counter.
module perf_counter
  import perf_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             wb_valid,
  input  logic             stall,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] disp,
  output logic             running,
  output logic             done,
  output logic             ovf
);

  state_t           r_state;
  state_t           w_next;
  logic             w_active;
  logic             w_force_ins;
  logic [WIDTH-1:0] r_disp;
  logic             r_ovf;

  logic [WIDTH-1:0] w_cyc_q;
  logic [WIDTH-1:0] w_ins_q;
  logic [WIDTH-1:0] w_stl_q;
  logic             w_cyc_sat;
  logic             w_ins_sat;
  logic             w_stl_sat;
  logic [WIDTH-1:0] w_status;
  logic [WIDTH-1:0] w_disp_next;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and counting qualifier; the start cycle itself is counted
  always_comb begin
    w_next      = r_state;
    w_active    = 1'b0;
    w_force_ins = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_active = 1'b1;
          if (stop) begin
            w_next      = S_HALTED;
            w_force_ins = 1'b1;
          end else begin
            w_next = S_COUNT;
          end
        end else if (stop) begin
          w_next = S_HALTED;
        end
      end
      S_COUNT: begin
        w_active = 1'b1;
        if (stop) begin
          w_next = S_HALTED;
        end
      end
      S_HALTED: begin
        w_next = S_HALTED;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  sat_counter #(.WIDTH(WIDTH)) u_cyc (
    .clock   (clock),
    .reset   (reset),
    .en      (w_active),
    .q       (w_cyc_q),
    .sat_hit (w_cyc_sat)
  );

  // A STOP seen together with start is itself the single retired instruction
  sat_counter #(.WIDTH(WIDTH)) u_ins (
    .clock   (clock),
    .reset   (reset),
    .en      (w_active & (wb_valid | w_force_ins)),
    .q       (w_ins_q),
    .sat_hit (w_ins_sat)
  );

`ifdef PERF_STALL_COUNT_EN
  sat_counter #(.WIDTH(WIDTH)) u_stl (
    .clock   (clock),
    .reset   (reset),
    .en      (w_active & stall),
    .q       (w_stl_q),
    .sat_hit (w_stl_sat)
  );
`else
  logic w_unused_stall;
  assign w_unused_stall = stall;
  assign w_stl_q        = '0;
  assign w_stl_sat      = 1'b0;
`endif

  // Sticky overflow, cleared only by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_cyc_sat || w_ins_sat || w_stl_sat) begin
      r_ovf <= 1'b1;
    end
  end

  assign running = (r_state == S_COUNT);
  assign done    = (r_state == S_HALTED);
  assign ovf     = r_ovf;

  // Status word and display select
  always_comb begin
    w_status                   = '0;
    w_status[STAT_RUNNING_BIT] = running;
    w_status[STAT_DONE_BIT]    = done;
    w_status[STAT_OVF_BIT]     = r_ovf;
    w_disp_next                = '0;
    case (sel)
      SEL_CYC:  w_disp_next = w_cyc_q;
      SEL_INS:  w_disp_next = w_ins_q;
      SEL_STL:  w_disp_next = w_stl_q;
      SEL_STAT: w_disp_next = w_status;
      default:  w_disp_next = '0;
    endcase
  end

  // Display register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_disp <= '0;
    end else begin
      r_disp <= w_disp_next;
    end
  end

  assign disp = r_disp;

endmodule

// File: tb/tb_perf_counter.sv
// Scoreboard bench for perf_counter: a 16-bit and a 4-bit instance share the
// same stimulus; expected display words are queued per program and compared
// as the display register presents them.
module tb_perf_counter;
  import perf_counter_pkg::*;

`ifdef PERF_STALL_COUNT_EN
  localparam bit STL_EN = 1'b1;
`else
  localparam bit STL_EN = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [1:0]  sel;
    logic [15:0] exp16;
    logic [3:0]  exp4;
  } sb_item_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic        stop;
  logic        wb_valid;
  logic        stall;
  logic [1:0]  sel;
  logic [15:0] disp16;
  logic [3:0]  disp4;
  logic        running16, done16, ovf16;
  logic        running4, done4, ovf4;

  sb_item_t sb[$];
  int       n_checks = 0;
  int       n_errors = 0;

  perf_counter #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .wb_valid(wb_valid), .stall(stall), .sel(sel),
    .disp(disp16), .running(running16), .done(done16), .ovf(ovf16)
  );

  perf_counter #(.WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .wb_valid(wb_valid), .stall(stall), .sel(sel),
    .disp(disp4), .running(running4), .done(done4), .ovf(ovf4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic clear_inputs();
    start = 1'b0; stop = 1'b0; wb_valid = 1'b0; stall = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Queue the four display words expected once a program has halted
  task automatic push_counts(input string t, input int cyc, input int ins, input int stl);
    int  stl_e;
    bit  o4;
    stl_e = STL_EN ? stl : 0;
    o4    = (cyc > 15) || (ins > 15) || (stl_e > 15);
    sb.push_back('{{t, "_cyc"},  SEL_CYC,  16'(cyc),   4'(sat4(cyc))});
    sb.push_back('{{t, "_ins"},  SEL_INS,  16'(ins),   4'(sat4(ins))});
    sb.push_back('{{t, "_stl"},  SEL_STL,  16'(stl_e), 4'(sat4(stl_e))});
    sb.push_back('{{t, "_stat"}, SEL_STAT, 16'h0002,   {1'b0, o4, 2'b10}});
  endtask

  // Present each queued select and compare after the display register updates
  task automatic drain();
    sb_item_t it;
    while (sb.size() > 0) begin
      sel = sb[0].sel;
      tick();
      it = sb.pop_front();
      check({it.tag, "_w16"}, 32'(disp16), 32'(it.exp16));
      check({it.tag, "_w4"},  32'(disp4),  32'(it.exp4));
    end
  endtask

  // n-cycle program: start on the first cycle, stop on the last; the last
  // nv cycles retire instructions, cycles 1..ns stall
  task automatic run_prog(input string t, input int n, input int nv, input int ns);
    for (int i = 0; i < n; i++) begin
      start    = (i == 0);
      stop     = (i == n - 1);
      wb_valid = (i >= n - nv);
      stall    = (i > 0) && (i <= ns);
      tick();
      if (i == 0 && n > 1) begin
        check({t, "_running"}, 32'(running16), 32'd1);
      end
    end
    clear_inputs();
    check({t, "_done"},     32'(done16),    32'd1);
    check({t, "_notrun"},   32'(running16), 32'd0);
    check({t, "_done4"},    32'(done4),     32'd1);
  endtask

  initial begin
    reset = 1'b0;
    sel   = SEL_CYC;
    clear_inputs();

    // Reset state
    do_reset();
    check("rst_disp",    32'(disp16),    32'd0);
    check("rst_disp4",   32'(disp4),     32'd0);
    check("rst_running", 32'(running16), 32'd0);
    check("rst_done",    32'(done16),    32'd0);
    check("rst_ovf",     32'(ovf16),     32'd0);

    // Ten-cycle program, start one cycle after reset
    tick();
    run_prog("t1", 10, 10, 0);
    push_counts("t1", 10, 10, 0);
    drain();

    // Twenty cycles, twelve retired; the 4-bit instance saturates
    do_reset();
    run_prog("t2", 20, 12, 0);
    check("t2_ovf16", 32'(ovf16), 32'd0);
    check("t2_ovf4",  32'(ovf4),  32'd1);
    push_counts("t2", 20, 12, 0);
    drain();

    // Pulses while halted change nothing
    for (int i = 0; i < 4; i++) begin
      start    = (i % 2 == 0);
      stop     = (i % 2 == 1);
      wb_valid = 1'b1;
      stall    = 1'b1;
      tick();
    end
    clear_inputs();
    check("halt_done",    32'(done16),    32'd1);
    check("halt_running", 32'(running16), 32'd0);
    push_counts("halt", 20, 12, 0);
    drain();

    // Stall counting over a 15-cycle run; 4-bit cycles land exactly at max
    do_reset();
    run_prog("t3", 15, 15, 5);
    push_counts("t3", 15, 15, 5);
    drain();

    // Reset mid-run wins over every other input
    do_reset();
    for (int i = 0; i < 7; i++) begin
      start    = (i == 0);
      wb_valid = 1'b1;
      stall    = 1'b1;
      tick();
    end
    reset = 1'b1; start = 1'b1; stop = 1'b1; wb_valid = 1'b1; stall = 1'b1;
    tick();
    reset = 1'b0;
    clear_inputs();
    check("mid_running", 32'(running16), 32'd0);
    check("mid_done",    32'(done16),    32'd0);
    check("mid_ovf",     32'(ovf16),     32'd0);
    check("mid_disp",    32'(disp16),    32'd0);
    sb.push_back('{"mid_cyc",  SEL_CYC,  16'h0000, 4'h0});
    sb.push_back('{"mid_ins",  SEL_INS,  16'h0000, 4'h0});
    sb.push_back('{"mid_stat", SEL_STAT, 16'h0000, 4'h0});
    drain();
    run_prog("t4", 3, 2, 1);
    push_counts("t4", 3, 2, 1);
    drain();

    // start and stop together in IDLE
    do_reset();
    run_prog("co", 1, 1, 0);
    push_counts("co", 1, 1, 0);
    drain();

    // stop without start in IDLE halts with zero counts
    do_reset();
    stop = 1'b1; wb_valid = 1'b1;
    tick();
    clear_inputs();
    check("ist_done", 32'(done16), 32'd1);
    push_counts("ist", 0, 0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
